alu_dispatch: RTL
=================

# alu_dispatch

Request front-end sitting directly upstream of the multi-cycle ALU (mulu/divu/shift/avg). Accepts operation requests over a valid/ready handshake, buffers them in a small FIFO, issues them one at a time to the ALU with a single-cycle `alu_valid` pulse, waits for the ALU's `alu_ready` pulse, and returns the 64-bit result tagged with a sequence number over a second valid/ready handshake. A watchdog flags ALU operations that never complete.

## Interface
- `DEPTH`, 4: request FIFO entries (power of two, ≥2)
- `TAG_W`, 4: sequence-tag width
- `TIMEOUT`, 63: max cycles in WAIT before error
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1; `req_ready` out 1: request handshake
- `req_mode` in 2: 0 mulu, 1 divu, 2 shift, 3 avg
- `req_a`, `req_b` in 32: operands
- `alu_valid` out 1; `alu_mode` out 2; `alu_a`, `alu_b` out 32: ALU issue
- `alu_ready` in 1; `alu_out` in 64: ALU completion, `alu_out` valid only while `alu_ready`=1
- `res_valid` out 1; `res_ready` in 1: result handshake
- `res_data` out 64; `res_tag` out TAG_W; `res_err` out 1: result payload
- `busy` out 1: FIFO non-empty or FSM not in IDLE

## Operation
- Push when `req_valid && req_ready`; `req_ready = !full`. When full, `req_ready`=0 even if a pop occurs that cycle.
- Each push assigns tag = push counter, wrapping modulo 2^TAG_W; tag stored with entry.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO non-empty and `res_valid`=0 → pop head into issue registers, go ISSUE.
  - ISSUE: `alu_valid`=1 for exactly this cycle; `alu_mode/a/b` from issue registers (held stable through WAIT). Go WAIT, clear watchdog.
  - WAIT: on `alu_ready` capture `alu_out` into `res_data`, `res_err`=0, go HOLD. Else when watchdog = TIMEOUT: `res_data`=0, `res_err`=1, go HOLD.
  - HOLD: `res_valid`=1; on `res_ready` go IDLE.
- `alu_ready` outside WAIT is ignored.
- `alu_valid` is never asserted in consecutive cycles; never asserted outside ISSUE.
- Result layout passed unmodified: mulu product [63:0]; divu remainder [63:32], quotient [31:0]; shift/avg in [31:0], upper zero.

## Timing
- Reset values: `req_ready`=1, `alu_valid`=0, `alu_mode/a/b`=0, `res_valid`=0, `res_data`=0, `res_tag`=0, `res_err`=0, `busy`=0; FIFO empty, tag counter 0, FSM IDLE.
- Push at cycle t, empty FIFO, idle → ISSUE at t+2 (pop in IDLE at t+1).
- ALU timing: valid at cycle v; `alu_ready` at v+33 for mulu/divu, v+2 for shift/avg. `res_valid` rises the cycle after `alu_ready`.
- After `res_ready` handshake at cycle h, next ISSUE earliest h+2; guarantees ALU is back in its idle state.
- Simultaneous push and pop on non-full FIFO: both occur, count unchanged.
- Reset mid-WAIT: FSM returns to IDLE, FIFO flushed; system resets ALU concurrently. Late `alu_ready` ignored.
- Watchdog counts cycles in WAIT starting at 0; error path leaves WAIT after TIMEOUT+1 cycles.

## Structure
- Package `alu_dispatch_pkg`: mode constants (`MODE_MULU`..`MODE_AVG`), FSM state enum, request entry width (2+32+32+TAG_W).
- Sub-module `alu_req_fifo`: synchronous FIFO, DEPTH/width parameters, push/pop/full/empty/count. Dispatcher FSM, watchdog, tag counter and result register stay in top.

## Test plan
- mulu a=3, b=5, `res_ready`=1 → single `alu_valid` pulse, `alu_ready` 33 cycles later, `res_data`=64'd15, tag 0, err 0.
- divu a=100, b=7 → `res_data[63:32]`=2, `[31:0]`=14; shift a=0x80, b=3 → 0x10; avg a=6, b=9 → 7; tags 1,2,3 in order.
- `res_ready`=0, push 6 requests → after 4 buffered + 1 in flight, `req_ready`=0; no second `alu_valid` until result consumed; all results in order.
- ALU model never asserts `alu_ready` → `res_valid` with `res_err`=1, `res_data`=0 after TIMEOUT+1 WAIT cycles; next request proceeds normally.
- Push 17 requests with TAG_W=4 → tags 0..15 then 0.
- Assert `rst` during WAIT of a mulu, then stray `alu_ready` → no `res_valid`, FIFO empty, `busy`=0.

Source files
------------

// File: rtl/alu_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// alu_dispatch_pkg
//
// Shared definitions for the multi-cycle ALU request front-end:
//   - ALU operation mode encodings
//   - dispatcher FSM state type
//   - operand/result widths and the packed request-entry width helper
//
// A request entry is packed as {tag, mode, a, b}, with b in the low bits.
// ---------------------------------------------------------------------------
package alu_dispatch_pkg;

    localparam int MODE_W = 2;
    localparam int OPND_W = 32;
    localparam int RES_W  = 64;

    localparam logic [MODE_W-1:0] MODE_MULU  = 2'd0;
    localparam logic [MODE_W-1:0] MODE_DIVU  = 2'd1;
    localparam logic [MODE_W-1:0] MODE_SHIFT = 2'd2;
    localparam logic [MODE_W-1:0] MODE_AVG   = 2'd3;

    // Bit positions of each field inside a packed request entry.
    localparam int ENTRY_B_LSB    = 0;
    localparam int ENTRY_A_LSB    = OPND_W;
    localparam int ENTRY_MODE_LSB = 2 * OPND_W;
    localparam int ENTRY_TAG_LSB  = 2 * OPND_W + MODE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } dispatch_state_t;

    // Width of one buffered request: mode + two operands + sequence tag.
    function automatic int reqEntryWidth(input int tagW);
        return MODE_W + 2 * OPND_W + tagW;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// ---------------------------------------------------------------------------
// alu_req_fifo
//
// Small synchronous FIFO holding pending ALU requests.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//   WIDTH  entry width in bits
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset, flushes the FIFO
//   i_push   write i_wdata (ignored when full)
//   i_wdata  entry to write
//   i_pop    drop the head entry (ignored when empty)
//   o_rdata  head entry, valid while o_empty is low
//   o_full   all DEPTH entries occupied
//   o_empty  no entries occupied
//   o_count  number of occupied entries
// ---------------------------------------------------------------------------
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 70
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rdPtr];

    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Storage array carries no reset; occupancy is tracked by the pointers
    // and count, so stale contents are never observed as valid.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A push and a
    // pop in the same cycle leave the count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_dispatch.sv
// ---------------------------------------------------------------------------
// alu_dispatch
//
// Request front-end for the multi-cycle ALU. Requests are buffered in a
// FIFO, tagged with a wrapping sequence number, issued one at a time with a
// single-cycle o_alu_valid pulse, and the ALU result is returned through a
// valid/ready handshake. A watchdog turns a never-completing ALU operation
// into an error result.
//
// Parameters:
//   DEPTH    request FIFO entries (power of two, >= 2)
//   TAG_W    sequence-tag width
//   TIMEOUT  max watchdog count in WAIT before the error path is taken
//
// Ports:
//   i_clk, i_rst                  clock / synchronous active-high reset
//   i_req_valid, o_req_ready      request handshake
//   i_req_mode, i_req_a, i_req_b  request payload
//   o_alu_valid                   single-cycle issue pulse
//   o_alu_mode, o_alu_a, o_alu_b  issued operation, stable through WAIT
//   i_alu_ready, i_alu_out        ALU completion pulse and result
//   o_res_valid, i_res_ready      result handshake
//   o_res_data, o_res_tag, o_res_err  result payload
//   o_busy                        work pending or in progress
// ---------------------------------------------------------------------------
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [1:0]         i_req_mode,
    input  logic [31:0]        i_req_a,
    input  logic [31:0]        i_req_b,
    output logic               o_alu_valid,
    output logic [1:0]         o_alu_mode,
    output logic [31:0]        o_alu_a,
    output logic [31:0]        o_alu_b,
    input  logic               i_alu_ready,
    input  logic [63:0]        i_alu_out,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [63:0]        o_res_data,
    output logic [TAG_W-1:0]   o_res_tag,
    output logic               o_res_err,
    output logic               o_busy
);

    localparam int ENTRY_W = reqEntryWidth(TAG_W);
    // Sized with headroom so the counter can always represent TIMEOUT.
    localparam int WD_W    = $clog2(TIMEOUT + 2);
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    dispatch_state_t r_state;
    dispatch_state_t w_nextState;

    logic [TAG_W-1:0]   r_tagCnt;
    logic [TAG_W-1:0]   r_issueTag;
    logic [MODE_W-1:0]  r_issueMode;
    logic [OPND_W-1:0]  r_issueA;
    logic [OPND_W-1:0]  r_issueB;
    logic [RES_W-1:0]   r_resData;
    logic               r_resErr;
    logic [WD_W-1:0]    r_wdog;

    logic               w_push;
    logic               w_pop;
    logic               w_capture;
    logic               w_timeout;
    logic               w_fifoFull;
    logic               w_fifoEmpty;
    logic [CNT_W-1:0]   w_fifoCount;
    logic [ENTRY_W-1:0] w_pushData;
    logic [ENTRY_W-1:0] w_headData;

    assign o_req_ready = !w_fifoFull;
    assign w_push      = i_req_valid && o_req_ready;
    assign w_pushData  = {r_tagCnt, i_req_mode, i_req_a, i_req_b};

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_reqFifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_pushData),
        .i_pop   (w_pop),
        .o_rdata (w_headData),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_count (w_fifoCount)
    );

    assign o_alu_valid = (r_state == ST_ISSUE);
    assign o_alu_mode  = r_issueMode;
    assign o_alu_a     = r_issueA;
    assign o_alu_b     = r_issueB;

    assign o_res_valid = (r_state == ST_HOLD);
    assign o_res_data  = r_resData;
    assign o_res_tag   = r_issueTag;
    assign o_res_err   = r_resErr;

    assign o_busy      = (w_fifoCount != '0) || (r_state != ST_IDLE);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and control decode. i_alu_ready only matters in WAIT, so a
    // late completion pulse after a reset or timeout is simply dropped. A
    // real completion wins over a watchdog expiry in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifoEmpty && !o_res_valid) begin
                    w_pop       = 1'b1;
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_alu_ready) begin
                    w_capture   = 1'b1;
                    w_nextState = ST_HOLD;
                end else if (r_wdog == WD_W'(TIMEOUT)) begin
                    w_timeout   = 1'b1;
                    w_nextState = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_res_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Datapath: tag counter, issue registers, watchdog and result register.
    // Issue registers are loaded on the pop so they are already stable in
    // the ISSUE cycle and stay unchanged until the next pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tagCnt    <= '0;
            r_issueTag  <= '0;
            r_issueMode <= '0;
            r_issueA    <= '0;
            r_issueB    <= '0;
            r_resData   <= '0;
            r_resErr    <= 1'b0;
            r_wdog      <= '0;
        end else begin
            if (w_push) begin
                r_tagCnt <= r_tagCnt + 1'b1;
            end

            if (w_pop) begin
                r_issueTag  <= w_headData[ENTRY_TAG_LSB  +: TAG_W];
                r_issueMode <= w_headData[ENTRY_MODE_LSB +: MODE_W];
                r_issueA    <= w_headData[ENTRY_A_LSB    +: OPND_W];
                r_issueB    <= w_headData[ENTRY_B_LSB    +: OPND_W];
            end

            // The watchdog reads 0 in the first WAIT cycle, so the error
            // path leaves WAIT after TIMEOUT+1 cycles.
            if (r_state == ST_ISSUE) begin
                r_wdog <= '0;
            end else if (r_state == ST_WAIT && !w_capture && !w_timeout) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_capture) begin
                r_resData <= i_alu_out;
                r_resErr  <= 1'b0;
            end else if (w_timeout) begin
                r_resData <= '0;
                r_resErr  <= 1'b1;
            end
        end
    end

endmodule
